// File: rtl/framebuffer_pkg.sv
// Framebuffer geometry and pixel-writer state encoding, shared by the
// pixel writer and the video fetch stage.
package framebuffer_pkg;

  localparam int H_RES          = 640;
  localparam int V_RES          = 480;
  localparam int WORDS_PER_LINE = 40;
  localparam int FB_WORDS       = V_RES * WORDS_PER_LINE;

  localparam logic [14:0] CLR_LAST = 15'(FB_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_REQ   = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_REQ   = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_CLR_REQ  = 3'd5,
    ST_CLR_WAIT = 3'd6
  } wr_state_e;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational x/y to framebuffer word address and pixel mask (pixel 0 = MSB).
module fb_addr_calc
  import framebuffer_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR = 18'd0
) (
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [17:0] word_addr,
  output logic [15:0] mask
);

  logic [17:0] y_ext_s;

  assign y_ext_s   = {8'd0, y};
  // y*40 as y*32 + y*8
  assign word_addr = BASE_ADDR + (y_ext_s << 5) + (y_ext_s << 3) + {12'd0, x[9:4]};
  assign mask      = 16'h8000 >> x[3:0];

endmodule

// File: rtl/sram_pixel_writer.sv
// Plots points into a 1 bpp SRAM framebuffer by read-modify-write and clears
// the whole frame on request; SRAM is touched only while window is high.
module sram_pixel_writer
  import framebuffer_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR = 18'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        point_valid,
  input  logic        clear,
  input  logic        window,
  output logic [17:0] address,
  output logic [15:0] data_write,
  output logic        read,
  output logic        write,
  input  logic [15:0] data_read,
  input  logic        ready,
  output logic        busy,
  output logic        dropped
);

  wr_state_e   state_r, state_next_s;
  logic        hold_full_r, hold_full_next_s;
  logic [9:0]  hold_x_r, hold_y_r;
  logic        clear_pending_r, clear_pending_next_s;
  logic        clr_restart_r, clr_restart_next_s;
  logic [14:0] clr_cnt_r, clr_cnt_next_s;
  logic [17:0] calc_addr_s, address_next_s;
  logic [15:0] calc_mask_s, data_write_next_s;
  logic        read_next_s, write_next_s;
  logic        point_ok_s, hold_free_s, accept_s;

  fb_addr_calc #(.BASE_ADDR(BASE_ADDR)) u_addr_calc (
    .x         (hold_x_r),
    .y         (hold_y_r),
    .word_addr (calc_addr_s),
    .mask      (calc_mask_s)
  );

  assign point_ok_s  = (x < 10'(H_RES)) && (y < 10'(V_RES));
  // The hold register frees on the write completion, so a point arriving that cycle still fits.
  assign hold_free_s = (state_r == ST_WR_WAIT) && ready;
  assign accept_s    = point_valid && point_ok_s && (!hold_full_r || hold_free_s) && !clear_pending_r;

  // Next-state, next-output and bookkeeping logic
  always_comb begin
    state_next_s         = state_r;
    clr_cnt_next_s       = clr_cnt_r;
    clr_restart_next_s   = clr_restart_r;
    clear_pending_next_s = clear_pending_r;
    address_next_s       = address;
    data_write_next_s    = data_write;
    read_next_s          = 1'b0;
    write_next_s         = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (window && clear_pending_r) begin
          state_next_s       = ST_CLR_REQ;
          clr_cnt_next_s     = 15'd0;
          clr_restart_next_s = 1'b0;
        end else if (window && hold_full_r) begin
          state_next_s   = ST_RD_REQ;
          read_next_s    = 1'b1;
          address_next_s = calc_addr_s;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RD_REQ: state_next_s = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (ready) begin
          data_write_next_s = data_read | calc_mask_s;
          write_next_s      = 1'b1;
          state_next_s      = ST_WR_REQ;
        end else begin
          state_next_s = ST_RD_WAIT;
        end
      end
      ST_WR_REQ: state_next_s = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WR_WAIT;
        end
      end
      ST_CLR_REQ: begin
        if (window) begin
          address_next_s    = BASE_ADDR + {3'd0, clr_cnt_r};
          data_write_next_s = 16'd0;
          write_next_s      = 1'b1;
          state_next_s      = ST_CLR_WAIT;
        end else begin
          state_next_s = ST_CLR_REQ;
        end
      end
      ST_CLR_WAIT: begin
        if (ready) begin
          if (clr_restart_r || clear) begin
            clr_cnt_next_s     = 15'd0;
            clr_restart_next_s = 1'b0;
            state_next_s       = ST_CLR_REQ;
          end else if (clr_cnt_r == CLR_LAST) begin
            clear_pending_next_s = 1'b0;
            state_next_s         = ST_IDLE;
          end else begin
            clr_cnt_next_s = clr_cnt_r + 15'd1;
            state_next_s   = ST_CLR_REQ;
          end
        end else begin
          state_next_s = ST_CLR_WAIT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase

    // A restart while a clear write is outstanding takes effect on its completion.
    if (clear) begin
      clear_pending_next_s = 1'b1;
      if (((state_r == ST_CLR_WAIT) && !ready) || ((state_r == ST_CLR_REQ) && window)) begin
        clr_restart_next_s = 1'b1;
      end else if (state_r == ST_CLR_REQ) begin
        clr_cnt_next_s = 15'd0;
      end else begin
        clr_restart_next_s = clr_restart_next_s;
      end
    end else begin
      clear_pending_next_s = clear_pending_next_s;
    end

    if (accept_s) begin
      hold_full_next_s = 1'b1;
    end else if (hold_free_s) begin
      hold_full_next_s = 1'b0;
    end else begin
      hold_full_next_s = hold_full_r;
    end
  end

  // State register, hold register, clear bookkeeping and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      hold_full_r     <= 1'b0;
      hold_x_r        <= 10'd0;
      hold_y_r        <= 10'd0;
      clear_pending_r <= 1'b0;
      clr_restart_r   <= 1'b0;
      clr_cnt_r       <= 15'd0;
      address         <= 18'd0;
      data_write      <= 16'd0;
      read            <= 1'b0;
      write           <= 1'b0;
      busy            <= 1'b0;
      dropped         <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      hold_full_r     <= hold_full_next_s;
      clear_pending_r <= clear_pending_next_s;
      clr_restart_r   <= clr_restart_next_s;
      clr_cnt_r       <= clr_cnt_next_s;
      address         <= address_next_s;
      data_write      <= data_write_next_s;
      read            <= read_next_s;
      write           <= write_next_s;
      busy            <= (state_next_s != ST_IDLE) || hold_full_next_s;
      dropped         <= point_valid && !accept_s;
      if (accept_s) begin
        hold_x_r <= x;
        hold_y_r <= y;
      end
    end
  end

endmodule

// File: doc/sram_pixel_writer.md
Name: sram_pixel_writer

Overview:
- Plots camera points into the 1 bpp framebuffer held in external SRAM. It sits between the camera x/y output and the sram controller's request port.
- Each point is a read-modify-write of one 16-pixel word. A frame clear writes zero to every framebuffer word.
- All SRAM accesses run only while the top-level access window is open (vertical blank), so they never collide with the video line fetch.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines.
- WORDS_PER_LINE, 40, 16-bit words per line (H_RES/16).
- BASE_ADDR, 0, SRAM word address of pixel (0,0).

Ports:
- clk  in  1  system clock (100 MHz board clock).
- reset  in  1  asynchronous, active-low reset.
- x  in  10  point x coordinate.
- y  in  10  point y coordinate.
- point_valid  in  1  one-cycle strobe; x/y valid this cycle.
- clear  in  1  one-cycle strobe; request a full-frame erase.
- window  in  1  high = SRAM access allowed.
- address  out  18  SRAM word address to controller.
- data_write  out  16  write data to controller.
- read  out  1  one-cycle read request.
- write  out  1  one-cycle write request.
- data_read  in  16  read data from controller, valid with ready.
- ready  in  1  one-cycle completion pulse from controller.
- busy  out  1  high while not IDLE or while the hold register is full.
- dropped  out  1  one-cycle pulse when a point is discarded.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; address=0, data_write=0, read=0, write=0, busy=0, dropped=0; hold register empty; clear_pending=0; clear counter=0.
- Point capture: on point_valid with x<H_RES and y<V_RES, load {x,y} into a 1-entry hold register if it is empty.
  - Drop (dropped pulses the next cycle) if the hold register is full, the point is out of range, or a clear is pending or active.
- Clear capture: a clear strobe sets clear_pending. A clear strobe while a clear is already active restarts the counter at 0.
- Address arithmetic: word = BASE_ADDR + y*WORDS_PER_LINE + x[9:4], computed as (y<<5)+(y<<3) for the default, 18-bit unsigned result. Bit index = x[3:0]; mask = 16'h8000 >> x[3:0], so pixel 0 is the MSB.
- Maximum address: 479*40+39 = 19199.
- State machine:
  - IDLE: if window=1 and clear_pending, go to CLR_REQ with counter=0. Else if window=1 and the hold register is full, go to RD_REQ. Clear has priority.
  - RD_REQ: drive address, pulse read for exactly 1 cycle, go to RD_WAIT.
  - RD_WAIT: on ready, latch data_write = data_read | mask, go to WR_REQ.
  - WR_REQ: pulse write for 1 cycle with address unchanged, go to WR_WAIT.
  - WR_WAIT: on ready, empty the hold register, go to IDLE.
  - CLR_REQ: wait while window=0. When window=1, address=BASE_ADDR+counter, data_write=0, pulse write, go to CLR_WAIT.
  - CLR_WAIT: on ready, increment counter. If counter = V_RES*WORDS_PER_LINE-1, clear clear_pending and go to IDLE; else go to CLR_REQ.
- Window drop mid-RMW: the current RMW completes; window is checked only when a new access starts.
- Simultaneous point_valid and write-completion: the hold register frees first, so the new point is accepted.
- Minimum RMW latency: window high to second ready = 4 cycles plus 2 controller latencies.
- Read and write are never asserted together. No request is issued while a previous one awaits ready.

Decomposition:
- Shared package (framebuffer_pkg): H_RES, V_RES, WORDS_PER_LINE, FB_WORDS (19200), state encoding constants. The video fetch stage reuses these.
- One sub-module: fb_addr_calc (combinational x/y to word address and mask), shared with the fetch stage.

Test Plan:
1. Point at x=17, y=2, window=1, SRAM word 81 preloaded with 16'h0001 -> read at address 81, then write 16'h4001 to 81; dropped stays 0.
2. Point at x=640, y=10 -> no SRAM access; dropped pulses once.
3. Two point strobes on consecutive cycles while in RD_WAIT -> second point accepted into the hold register only if the first has completed, else dropped pulses; each accepted point gives exactly one read and one write.
4. Clear with window toggled every 50 cycles -> writes of 0 to addresses 0..19199 in order, none issued while window=0, then busy falls.
5. Point held with window=0 -> no read issued; window rises -> read occurs 1 cycle later.
6. Reset asserted during WR_WAIT -> all outputs 0 immediately; after release no stray write; the hold register is empty.
